// File: rtl/pebble_run_ctrl.sv
// Run controller for the Pebble core: owns core reset, sequences a run, arbitrates the data memory port.
// Memory mux is combinational; run status (done/timeout/cycle_count) is registered.
module pebble_run_ctrl #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              core_done,
    output logic              core_reset,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);
    localparam int unsigned       RW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RW-1:0]     RST_LOAD = RW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_start_q;
    logic [RW-1:0]     r_rst_cnt, w_rst_cnt_nxt;
    logic [CNT_W-1:0]  r_cycle_count, w_cycle_count_nxt;
    logic              r_done, w_done_nxt;
    logic              r_timeout, w_timeout_nxt;
    logic              w_start_pulse;

    assign w_start_pulse = start & ~r_start_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_start_q     <= 1'b0;
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_start_q     <= start;
            r_rst_cnt     <= w_rst_cnt_nxt;
            r_cycle_count <= w_cycle_count_nxt;
            r_done        <= w_done_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rst_cnt_nxt     = r_rst_cnt;
        w_cycle_count_nxt = r_cycle_count;
        w_done_nxt        = r_done;
        w_timeout_nxt     = r_timeout;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_pulse) begin
                    w_state_nxt       = S_RESET;
                    w_rst_cnt_nxt     = RST_LOAD;
                    w_cycle_count_nxt = '0;
                    w_done_nxt        = 1'b0;
                    w_timeout_nxt     = 1'b0;
                end
            end
            S_RESET: begin
                if (r_rst_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt - 1'b1;
                end
            end
            S_RUN: begin
                w_cycle_count_nxt = r_cycle_count + 1'b1;
                // core_done is checked first so a finish on the limit cycle is not a timeout
                if (core_done) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else if (r_cycle_count == CNT_LAST) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        host_gnt  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        case (r_state)
            S_RUN: begin
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
            end
            S_IDLE, S_DONE: begin
                host_gnt = host_req;
                mem_we   = host_req & host_we;
            end
            default: begin
                host_gnt = 1'b0;
                mem_we   = 1'b0;
            end
        endcase
    end

    assign host_rdata  = mem_rdata;
    assign core_reset  = (r_state != S_RUN);
    assign busy        = (r_state == S_RESET) || (r_state == S_RUN);
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pebble_run_ctrl.sv
// Bench for pebble_run_ctrl: table of runs plus random runs against a run-length/memory reference model.
module tb_pebble_run_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int RC = 2;
    localparam int MC = 20;

    logic          clk, reset_n, start, core_done, core_reset, core_we;
    logic          host_req, host_we, host_gnt, mem_we, busy, done, timeout;
    logic [AW-1:0] core_addr, host_addr, mem_addr;
    logic [DW-1:0] core_wdata, host_wdata, host_rdata, mem_wdata, mem_rdata;
    logic [CW-1:0] cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] ref_mem [256];

    typedef struct {
        int n_done;
        int exp_cnt;
        bit exp_to;
        bit hold;
        bit jitter;
        bit arb;
    } run_vec_t;

    run_vec_t tbl [7];

    pebble_run_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .RESET_CYCLES(RC), .MAX_CYCLES(MC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .core_done(core_done),
        .core_reset(core_reset), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr];
    always @(posedge clk) if (mem_we) mem_arr[mem_addr] <= mem_wdata;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        chk("host_wr_gnt", host_gnt, 1'b1);
        chk("host_wr_mem_we", mem_we, 1'b1);
        chk("host_wr_mem_addr", mem_addr, a);
        ref_mem[a] = d;
        next_cyc();
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a);
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        @(negedge clk);
        chk("host_rd_gnt", host_gnt, 1'b1);
        chk("host_rd_mem_we", mem_we, 1'b0);
        chk("host_rd_data", host_rdata, ref_mem[a]);
        next_cyc();
        host_req = 1'b0;
    endtask

    // One complete run: start pulse, RESET window, RUN until done/limit, DONE checks.
    task automatic do_run(input run_vec_t v);
        int k;
        start = 1'b0; core_done = 1'b0; host_req = 1'b0; core_we = 1'b0;
        next_cyc();
        start = 1'b1;
        @(negedge clk);
        chk("pre_start_busy", busy, 1'b0);
        chk("pre_start_core_reset", core_reset, 1'b1);
        next_cyc();
        if (!v.hold) start = 1'b0;
        for (int r = 1; r <= RC; r++) begin
            host_req = 1'b1; host_we = 1'b1; core_we = 1'b1; host_addr = 8'hEE;
            @(negedge clk);
            chk("rst_core_reset", core_reset, 1'b1);
            chk("rst_busy", busy, 1'b1);
            chk("rst_host_gnt", host_gnt, 1'b0);
            chk("rst_mem_we", mem_we, 1'b0);
            if (r == 1) begin
                chk("rst_done_clr", done, 1'b0);
                chk("rst_timeout_clr", timeout, 1'b0);
                chk("rst_count_clr", cycle_count, 0);
            end
            next_cyc();
        end
        k = 1;
        forever begin
            core_done = (k == v.n_done);
            if (v.arb) begin
                core_we = 1'b1; core_addr = 8'h10; core_wdata = DW'($urandom);
                host_req = 1'b1; host_we = 1'b1; host_addr = 8'h33; host_wdata = 8'h5C;
            end else begin
                core_we = 1'($urandom_range(0, 1)); core_addr = AW'($urandom);
                core_wdata = DW'($urandom);
                host_req = 1'($urandom_range(0, 1)); host_we = 1'($urandom_range(0, 1));
                host_addr = AW'($urandom);
            end
            if (v.jitter) start = k[1];
            @(negedge clk);
            chk("run_core_reset", core_reset, 1'b0);
            chk("run_busy", busy, 1'b1);
            chk("run_done", done, 1'b0);
            chk("run_count", cycle_count, k - 1);
            chk("run_host_gnt", host_gnt, 1'b0);
            chk("run_mem_addr", mem_addr, core_addr);
            chk("run_mem_we", mem_we, core_we);
            if (core_we) ref_mem[core_addr] = core_wdata;
            next_cyc();
            if (k == v.n_done || k == MC) break;
            k++;
        end
        core_done = 1'b0; core_we = 1'b0;
        if (!v.arb) host_req = 1'b0;
        if (!v.hold) start = 1'b0;
        @(negedge clk);
        chk("done_flag", done, 1'b1);
        chk("done_timeout", timeout, v.exp_to);
        chk("done_count", cycle_count, v.exp_cnt);
        chk("done_busy", busy, 1'b0);
        chk("done_core_reset", core_reset, 1'b1);
        if (v.arb) begin
            chk("arb_gnt_first_done", host_gnt, 1'b1);
            chk("arb_mem_addr", mem_addr, 8'h33);
            chk("arb_mem_we", mem_we, 1'b1);
            ref_mem[8'h33] = 8'h5C;
        end
        next_cyc();
        host_req = 1'b0;
        if (v.hold) begin
            for (int h = 0; h < 4; h++) begin
                @(negedge clk);
                chk("hold_no_rerun_busy", busy, 1'b0);
                chk("hold_done_kept", done, 1'b1);
                chk("hold_count_kept", cycle_count, v.exp_cnt);
                next_cyc();
            end
            start = 1'b0;
        end
    endtask

    initial begin
        run_vec_t rv;
        int nd;
        tbl[0] = '{n_done: 10, exp_cnt: 10, exp_to: 1'b0, hold: 1'b0, jitter: 1'b0, arb: 1'b0};
        tbl[1] = '{n_done: 0,  exp_cnt: 20, exp_to: 1'b1, hold: 1'b0, jitter: 1'b0, arb: 1'b0};
        tbl[2] = '{n_done: 20, exp_cnt: 20, exp_to: 1'b0, hold: 1'b0, jitter: 1'b0, arb: 1'b0};
        tbl[3] = '{n_done: 12, exp_cnt: 12, exp_to: 1'b0, hold: 1'b0, jitter: 1'b1, arb: 1'b0};
        tbl[4] = '{n_done: 7,  exp_cnt: 7,  exp_to: 1'b0, hold: 1'b1, jitter: 1'b0, arb: 1'b0};
        tbl[5] = '{n_done: 15, exp_cnt: 15, exp_to: 1'b0, hold: 1'b0, jitter: 1'b0, arb: 1'b1};
        tbl[6] = '{n_done: 1,  exp_cnt: 1,  exp_to: 1'b0, hold: 1'b0, jitter: 1'b0, arb: 1'b0};

        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        reset_n = 1'b0; start = 1'b0; core_done = 1'b0; core_we = 1'b0;
        core_addr = '0; core_wdata = '0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0;
        #23;
        chk("reset_core_reset", core_reset, 1'b1);
        chk("reset_done", done, 1'b0);
        chk("reset_timeout", timeout, 1'b0);
        chk("reset_count", cycle_count, 0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_mem_we", mem_we, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        next_cyc();

        host_write(8'h05, 8'h2A);
        host_read(8'h05);

        for (int i = 0; i < 7; i++) begin
            do_run(tbl[i]);
            host_read(8'h05);
            if (tbl[i].arb) host_read(8'h33);
        end

        // Abort: reset asserted during RUN cycle 5
        start = 1'b0;
        next_cyc();
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        repeat (RC + 4) next_cyc();
        @(negedge clk);
        chk("abort_pre_count", cycle_count, 4);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_core_reset", core_reset, 1'b1);
        chk("abort_count", cycle_count, 0);
        chk("abort_done", done, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
            chk("abort_idle_busy", busy, 1'b0);
            next_cyc();
        end
        host_read(8'h05);

        // Random runs: expected result is the run length clipped at the limit
        for (int i = 0; i < 12; i++) begin
            nd = $urandom_range(0, MC + 4);
            rv.n_done  = nd;
            rv.exp_cnt = (nd == 0 || nd > MC) ? MC : nd;
            rv.exp_to  = (nd == 0 || nd > MC);
            rv.hold    = 1'b0;
            rv.jitter  = 1'($urandom_range(0, 1));
            rv.arb     = 1'b0;
            do_run(rv);
            host_write(AW'($urandom), DW'($urandom));
            host_read(AW'($urandom));
            host_read(8'h05);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
